axi_dac_reader: RTL and testbench

Streaming AXI3 read master that fetches 16-bit DAC samples from a circular DDR buffer over an HP port and delivers them one per request to the DAC generator path. It is the read-side counterpart of the scope's HP write path and uses the same memory layout: 64-bit beats, four 16-bit lanes, lane 0 (bits 15:0) is the oldest sample, and the 14-bit sample sits in lane bits 13:0. It sits between `ps.system_i` HP slave ports and the DAC output stage.

---
 rtl/axi_dac_reader.sv | 164 ++++++++++++++++
 tb/tb_axi_dac_reader.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dac_reader.sv
// Streaming AXI3 read master: fetches 64-bit beats from a circular DDR buffer into a beat FIFO
// and hands out one 16-bit lane (oldest first) per DAC request.
module axi_dac_reader #(
   parameter int unsigned BURST_LEN  = 16,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned DAC_DW     = 14
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [31:0]                   cfg_start_addr_i,
   input  logic [31:0]                   cfg_stop_addr_i,
   input  logic                          ctrl_start_i,
   input  logic                          ctrl_stop_i,
   output logic                          busy_o,
   output logic                          err_o,
   output logic [31:0]                   underrun_cnt_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl_o,
   output logic [31:0]                   axi_araddr_o,
   output logic [3:0]                    axi_arlen_o,
   output logic [2:0]                    axi_arsize_o,
   output logic [1:0]                    axi_arburst_o,
   output logic                          axi_arvalid_o,
   input  logic                          axi_arready_i,
   input  logic [63:0]                   axi_rdata_i,
   input  logic [1:0]                    axi_rresp_i,
   input  logic                          axi_rlast_i,
   input  logic                          axi_rvalid_i,
   output logic                          axi_rready_o,
   input  logic                          dac_rdy_i,
   output logic [DAC_DW-1:0]             dac_dat_o,
   output logic                          dac_dv_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);

   typedef logic [AW:0] lvl_t;
   localparam lvl_t CREDIT_MAX = lvl_t'(FIFO_DEPTH - BURST_LEN);

   typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_t;

   state_t            state, state_next;
   logic [63:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_idx, rd_idx;
   lvl_t              lvl;
   logic [1:0]        lane;
   logic              busy, stop_pend, err;
   logic [31:0]       rd_ptr, underrun;
   logic [DAC_DW-1:0] dac_dat;
   logic              dac_dv;

   logic              start_go, idle_stop, flush, push, beat_last, ar_hs;
   logic              credit_ok, take, starve, pop;
   logic [31:0]       ptr_inc;
   logic [63:0]       fifo_head;

   always_comb begin
      start_go  = (state == StIdle) && !busy && ctrl_start_i && !ctrl_stop_i;
      idle_stop = (state == StIdle) && ctrl_stop_i;
      flush     = start_go || idle_stop || (state == StDrain);
      push      = (state == StData) && axi_rvalid_i;
      beat_last = push && axi_rlast_i;
      ar_hs     = (state == StAddr) && axi_arready_i;
      // Only request a burst when a whole burst is guaranteed to fit.
      credit_ok = busy && (lvl <= CREDIT_MAX);
      take      = dac_rdy_i && busy && (lvl != '0) && !flush;
      starve    = dac_rdy_i && busy && (lvl == '0);
      pop       = take && (lane == 2'd3);
      ptr_inc   = rd_ptr + BURST_BYTES;
      fifo_head = mem[rd_idx];

      state_next = state;
      unique case (state)
         StIdle:  if (!idle_stop && credit_ok) state_next = StAddr;
         StAddr:  if (axi_arready_i) state_next = StData;
         StData:  if (beat_last) state_next = (stop_pend || ctrl_stop_i) ? StDrain : StIdle;
         StDrain: state_next = StIdle;
         default: state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= StIdle;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy      <= 1'b0;
         stop_pend <= 1'b0;
         err       <= 1'b0;
         rd_ptr    <= '0;
         underrun  <= '0;
      end else begin
         if (start_go) begin
            busy     <= 1'b1;
            rd_ptr   <= cfg_start_addr_i;
            err      <= 1'b0;
            underrun <= '0;
         end else begin
            if (idle_stop || (state == StDrain)) busy <= 1'b0;
            if (ar_hs) rd_ptr <= (ptr_inc >= cfg_stop_addr_i) ? cfg_start_addr_i : ptr_inc;
            if (push && (axi_rresp_i != 2'b00)) err <= 1'b1;
            if (starve && (underrun != '1)) underrun <= underrun + 32'd1;
         end
         // A stop seen in ADDR/DATA cannot retract the burst; it takes effect via DRAIN.
         if (state == StDrain) begin
            stop_pend <= 1'b0;
         end else if (ctrl_stop_i && ((state == StAddr) || (state == StData))) begin
            stop_pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_idx] <= axi_rdata_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_idx <= '0;
         rd_idx <= '0;
         lvl    <= '0;
         lane   <= '0;
      end else if (flush) begin
         wr_idx <= '0;
         rd_idx <= '0;
         lvl    <= '0;
         lane   <= '0;
      end else begin
         if (push) wr_idx <= wr_idx + 1'b1;
         if (pop) rd_idx <= rd_idx + 1'b1;
         if (take) lane <= lane + 2'd1;
         lvl <= lvl + lvl_t'(push) - lvl_t'(pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dac_dat <= '0;
         dac_dv  <= 1'b0;
      end else begin
         dac_dv <= take;
         if (take) dac_dat <= fifo_head[{lane, 4'b0000} +: DAC_DW];
      end
   end

   assign busy_o         = busy;
   assign err_o          = err;
   assign underrun_cnt_o = underrun;
   assign fifo_lvl_o     = lvl;
   assign axi_araddr_o   = rd_ptr;
   assign axi_arlen_o    = 4'(BURST_LEN - 1);
   assign axi_arsize_o   = 3'd3;
   assign axi_arburst_o  = 2'b01;
   assign axi_arvalid_o  = (state == StAddr);
   assign axi_rready_o   = (state == StData);
   assign dac_dat_o      = dac_dat;
   assign dac_dv_o       = dac_dv;

endmodule

// File: tb/tb_axi_dac_reader.sv
// Directed bench for axi_dac_reader: a zero/fixed-wait AXI read slave serves beat k of the buffer
// as {4k+3, 4k+2, 4k+1, 4k}, so the expected sample stream is 0, 1, 2, ... modulo 128.
`timescale 1ns/1ps
module tb_axi_dac_reader;

   localparam int BL    = 16;
   localparam int DEPTH = 64;
   localparam int DW    = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   cfg_start = 32'h1000;
   logic [31:0]   cfg_stop = 32'h1100;
   logic          ctrl_start = 1'b0;
   logic          ctrl_stop = 1'b0;
   logic          busy, err;
   logic [31:0]   underrun;
   logic [6:0]    fifo_lvl;
   logic [31:0]   araddr;
   logic [3:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid, rready, dac_dv;
   logic          arready = 1'b0;
   logic [63:0]   rdata = '0;
   logic [1:0]    rresp = '0;
   logic          rlast = 1'b0;
   logic          rvalid = 1'b0;
   logic          dac_rdy = 1'b0;
   logic [DW-1:0] dac_dat;

   int n_checks = 0;
   int n_fail = 0;

   int          ar_wait = 0;
   int          err_beat = -1;
   int          slv_st = 0;
   int          wait_cnt = 0;
   int          slv_beat = 0;
   int          tot_beats = 0;
   int          ar_count = 0;
   logic [31:0] slv_addr = '0;
   logic        acc = 1'b0;
   logic [31:0] ar_log[$];

   axi_dac_reader #(.BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .DAC_DW(DW)) dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_start_addr_i(cfg_start), .cfg_stop_addr_i(cfg_stop),
      .ctrl_start_i(ctrl_start), .ctrl_stop_i(ctrl_stop),
      .busy_o(busy), .err_o(err), .underrun_cnt_o(underrun), .fifo_lvl_o(fifo_lvl),
      .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
      .axi_arburst_o(arburst), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
      .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
      .axi_rvalid_i(rvalid), .axi_rready_o(rready),
      .dac_rdy_i(dac_rdy), .dac_dat_o(dac_dat), .dac_dv_o(dac_dv)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [63:0] beat_data(input logic [31:0] addr, input int b);
      int k;
      k = int'((addr - 32'h1000) >> 3) + b;
      return {16'(4 * k + 3), 16'(4 * k + 2), 16'(4 * k + 1), 16'(4 * k)};
   endfunction

   task automatic slv_present();
      rvalid = 1'b1;
      rdata  = beat_data(slv_addr, slv_beat);
      rlast  = (slv_beat == BL - 1);
      rresp  = (tot_beats == err_beat) ? 2'b10 : 2'b00;
      tot_beats++;
      acc = rready;
   endtask

   // AXI read slave: drives 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            slv_st = 0; wait_cnt = 0; tot_beats = 0; ar_count = 0;
            ar_log.delete();
         end else begin
            case (slv_st)
               0: if (arvalid) begin
                     if (wait_cnt >= ar_wait) begin
                        arready = 1'b1;
                        slv_addr = araddr;
                        ar_log.push_back(araddr);
                        ar_count++;
                        slv_st = 1;
                     end else begin
                        wait_cnt++;
                     end
                  end
               1: begin
                     arready = 1'b0;
                     wait_cnt = 0;
                     slv_beat = 0;
                     slv_present();
                     slv_st = 2;
                  end
               default: begin
                     if (acc) begin
                        if (rlast) begin
                           rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                           slv_st = 0;
                        end else begin
                           slv_beat++;
                           slv_present();
                        end
                     end else begin
                        acc = rready;
                     end
                  end
            endcase
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      ctrl_start = 1'b0; ctrl_stop = 1'b0; dac_rdy = 1'b0;
      cfg_start = 32'h1000; cfg_stop = 32'h1100;
      ar_wait = 0; err_beat = -1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      ctrl_start = 1'b1;
      @(negedge clk);
      ctrl_start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({busy, err, arvalid, rready, dac_dv} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 00000", {busy, err, arvalid, rready, dac_dv});
      end
      n_checks++;
      if (underrun !== 32'd0) begin
         n_fail++; $display("FAIL reset_underrun: got %0d expected 0", underrun);
      end
      n_checks++;
      if (fifo_lvl !== 7'd0) begin
         n_fail++; $display("FAIL reset_lvl: got %0d expected 0", fifo_lvl);
      end
      n_checks++;
      if (araddr !== 32'd0 || dac_dat !== '0) begin
         n_fail++; $display("FAIL reset_addr_dat: got %h/%h expected 0/0", araddr, dac_dat);
      end
      n_checks++;
      if ({arlen, arsize, arburst} !== {4'd15, 3'd3, 2'b01}) begin
         n_fail++;
         $display("FAIL reset_consts: got %0d/%0d/%0d expected 15/3/1", arlen, arsize, arburst);
      end
   endtask

   task automatic test_stream();
      int exp_s;
      do_reset();
      pulse_start();
      repeat (40) @(negedge clk);
      exp_s = 0;
      for (int i = 0; i <= 300; i++) begin
         if (dac_dv) begin
            n_checks++;
            if (dac_dat !== DW'(exp_s % 128)) begin
               n_fail++;
               $display("FAIL stream_sample[%0d]: got %0d expected %0d", exp_s, dac_dat, exp_s % 128);
            end
            exp_s++;
         end
         dac_rdy = (i < 300);
         @(negedge clk);
      end
      if (dac_dv) exp_s++;
      n_checks++;
      if (exp_s != 300) begin
         n_fail++; $display("FAIL stream_count: got %0d expected 300", exp_s);
      end
      n_checks++;
      if (underrun !== 32'd0) begin
         n_fail++; $display("FAIL stream_underrun: got %0d expected 0", underrun);
      end
      n_checks++;
      if (ar_log.size() < 3 || ar_log[0] !== 32'h1000 || ar_log[1] !== 32'h1080
          || ar_log[2] !== 32'h1000) begin
         n_fail++;
         $display("FAIL stream_araddr: got %h %h %h expected 1000 1080 1000",
                  ar_log[0], ar_log[1], ar_log[2]);
      end
   endtask

   task automatic test_zero_wait();
      int exp_s, first_dv, first_rlast, second_ar, rises;
      logic prev_arv;
      do_reset();
      dac_rdy = 1'b1;
      ctrl_start = 1'b1;
      exp_s = 0; first_dv = -1; first_rlast = -1; second_ar = -1; rises = 0; prev_arv = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         ctrl_start = 1'b0;
         if (c == 1) begin
            n_checks++;
            if (busy !== 1'b1 || arvalid !== 1'b0) begin
               n_fail++; $display("FAIL zw_cycle1: got busy=%b arvalid=%b expected 1/0", busy, arvalid);
            end
         end
         if (c == 2) begin
            n_checks++;
            if (arvalid !== 1'b1 || araddr !== 32'h1000) begin
               n_fail++; $display("FAIL zw_arvalid: got %b/%h expected 1/1000", arvalid, araddr);
            end
         end
         if (c == 3) begin
            n_checks++;
            if (underrun !== 32'd2) begin
               n_fail++; $display("FAIL zw_underrun_c3: got %0d expected 2", underrun);
            end
         end
         if (dac_dv) begin
            if (first_dv < 0) first_dv = c;
            n_checks++;
            if (dac_dat !== DW'(exp_s % 128)) begin
               n_fail++;
               $display("FAIL zw_sample[%0d]: got %0d expected %0d", exp_s, dac_dat, exp_s % 128);
            end
            exp_s++;
         end
         if (rvalid && rlast && rready && first_rlast < 0) first_rlast = c;
         if (arvalid && !prev_arv) begin
            rises++;
            if (rises == 2) second_ar = c;
         end
         prev_arv = arvalid;
      end
      dac_rdy = 1'b0;
      n_checks++;
      if (first_dv != 5) begin
         n_fail++; $display("FAIL zw_first_dv: got cycle %0d expected 5", first_dv);
      end
      n_checks++;
      if (underrun !== 32'd3) begin
         n_fail++; $display("FAIL zw_underrun: got %0d expected 3", underrun);
      end
      n_checks++;
      if (exp_s != 296) begin
         n_fail++; $display("FAIL zw_no_stall: got %0d samples expected 296", exp_s);
      end
      n_checks++;
      if (first_rlast != 18 || second_ar != 20) begin
         n_fail++;
         $display("FAIL zw_b2b: got rlast=%0d ar=%0d expected 18/20", first_rlast, second_ar);
      end
   endtask

   task automatic test_backpressure();
      int exp_s;
      do_reset();
      pulse_start();
      repeat (150) @(negedge clk);
      n_checks++;
      if (ar_count != 4 || fifo_lvl !== 7'd64 || arvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_full: got bursts=%0d lvl=%0d arvalid=%b expected 4/64/0",
                  ar_count, fifo_lvl, arvalid);
      end
      exp_s = 0;
      for (int i = 0; i <= 60; i++) begin
         if (dac_dv) begin
            n_checks++;
            if (dac_dat !== DW'(exp_s)) begin
               n_fail++; $display("FAIL bp_sample[%0d]: got %0d expected %0d", exp_s, dac_dat, exp_s);
            end
            exp_s++;
         end
         dac_rdy = (i < 60);
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      n_checks++;
      if (ar_count != 4 || fifo_lvl !== 7'd49 || arvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_hold: got bursts=%0d lvl=%0d arvalid=%b expected 4/49/0",
                  ar_count, fifo_lvl, arvalid);
      end
      dac_rdy = 1'b1;
      repeat (4) @(negedge clk);
      dac_rdy = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (ar_count != 5) begin
         n_fail++; $display("FAIL bp_fifth_burst: got %0d bursts expected 5", ar_count);
      end
   endtask

   task automatic test_stop_mid_burst();
      int found, rlast_seen, rready_drop;
      do_reset();
      pulse_start();
      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
         if (rvalid && slv_beat == 5) found = 1;
         else @(negedge clk);
      end
      n_checks++;
      if (found != 1) begin
         n_fail++; $display("FAIL stop_find_beat5: got %0d expected 1", found);
      end
      ctrl_stop = 1'b1;
      @(negedge clk);
      ctrl_stop = 1'b0;
      rlast_seen = 0; rready_drop = 0;
      for (int i = 0; i < 40 && rlast_seen == 0; i++) begin
         if (!rready) rready_drop++;
         if (rvalid && rlast) rlast_seen = 1;
         else @(negedge clk);
      end
      n_checks++;
      if (rlast_seen != 1 || rready_drop != 0) begin
         n_fail++;
         $display("FAIL stop_rready: got rlast=%0d drops=%0d expected 1/0", rlast_seen, rready_drop);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL stop_busy_r1: got %b expected 1", busy);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || fifo_lvl !== 7'd0) begin
         n_fail++; $display("FAIL stop_busy_r2: got busy=%b lvl=%0d expected 0/0", busy, fifo_lvl);
      end
      repeat (30) @(negedge clk);
      n_checks++;
      if (ar_count != 1 || arvalid !== 1'b0) begin
         n_fail++; $display("FAIL stop_no_ar: got bursts=%0d arvalid=%b expected 1/0", ar_count, arvalid);
      end
   endtask

   task automatic test_rresp_err();
      int exp_s, idle_wait;
      do_reset();
      err_beat = 2;
      dac_rdy = 1'b1;
      ctrl_start = 1'b1;
      exp_s = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         ctrl_start = 1'b0;
         if (c == 5 || c == 6) begin
            n_checks++;
            if (err !== (c == 6)) begin
               n_fail++; $display("FAIL err_set_c%0d: got %b expected %0d", c, err, c == 6);
            end
         end
         if (dac_dv) begin
            n_checks++;
            if (dac_dat !== DW'(exp_s % 128)) begin
               n_fail++;
               $display("FAIL err_sample[%0d]: got %0d expected %0d", exp_s, dac_dat, exp_s % 128);
            end
            exp_s++;
         end
      end
      dac_rdy = 1'b0;
      n_checks++;
      if (exp_s != 36 || underrun !== 32'd3) begin
         n_fail++; $display("FAIL err_stream: got %0d/%0d expected 36/3", exp_s, underrun);
      end
      ctrl_stop = 1'b1;
      @(negedge clk);
      ctrl_stop = 1'b0;
      idle_wait = 0;
      while (busy && idle_wait < 60) begin
         @(negedge clk);
         idle_wait++;
      end
      n_checks++;
      if (busy !== 1'b0 || err !== 1'b1) begin
         n_fail++; $display("FAIL err_sticky: got busy=%b err=%b expected 0/1", busy, err);
      end
      pulse_start();
      n_checks++;
      if (err !== 1'b0 || underrun !== 32'd0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL err_restart: got err=%b underrun=%0d busy=%b expected 0/0/1",
                  err, underrun, busy);
      end
   endtask

   task automatic test_arready_stall();
      int hs, unstable, waited, rlast_seen;
      do_reset();
      ar_wait = 20;
      pulse_start();
      @(negedge clk);
      hs = 0; unstable = 0; waited = 0;
      for (int i = 0; i < 60 && hs == 0; i++) begin
         if (!arvalid || araddr !== 32'h1000) unstable++;
         ctrl_stop = (i == 10);
         if (arready) hs = 1;
         else begin
            @(negedge clk);
            waited++;
         end
      end
      ctrl_stop = 1'b0;
      n_checks++;
      if (hs != 1 || unstable != 0 || waited != 20) begin
         n_fail++;
         $display("FAIL stall_ar_stable: got hs=%0d unstable=%0d waited=%0d expected 1/0/20",
                  hs, unstable, waited);
      end
      rlast_seen = 0;
      for (int i = 0; i < 40 && rlast_seen == 0; i++) begin
         @(negedge clk);
         if (rvalid && rlast && rready) rlast_seen = 1;
      end
      n_checks++;
      if (rlast_seen != 1) begin
         n_fail++; $display("FAIL stall_burst_done: got %0d expected 1", rlast_seen);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || fifo_lvl !== 7'd0) begin
         n_fail++; $display("FAIL stall_idle: got busy=%b lvl=%0d expected 0/0", busy, fifo_lvl);
      end
      repeat (30) @(negedge clk);
      n_checks++;
      if (ar_count != 1 || arvalid !== 1'b0) begin
         n_fail++; $display("FAIL stall_no_ar: got bursts=%0d arvalid=%b expected 1/0", ar_count, arvalid);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_zero_wait();
      test_backpressure();
      test_stop_mid_burst();
      test_rresp_err();
      test_arready_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
